// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP slice post-multiplier datapath.
//   DSP_MULT_W / DSP_ACC_W : default product and accumulator widths
//   ACC_SAT_MAX / MIN      : signed clamp limits at the default accumulator width
//   acc_state_t            : accumulator frame state (IDLE = no frame open)
package dsp_pkg;

  localparam int DSP_MULT_W = 43;
  localparam int DSP_ACC_W  = 48;

  localparam logic signed [DSP_ACC_W-1:0] ACC_SAT_MAX = {1'b0, {(DSP_ACC_W-1){1'b1}}};
  localparam logic signed [DSP_ACC_W-1:0] ACC_SAT_MIN = {1'b1, {(DSP_ACC_W-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: sign-extends the product, optionally negates
// it, adds it to the running accumulator and reports signed overflow direction.
// With SATURATE != 0 an overflowing result is clamped to the signed limits.
//   acc     : current accumulator value
//   prod    : signed multiplier product
//   sub     : 1 = subtract the product, 0 = add
//   sum     : new accumulator value (wrapped or clamped)
//   ovf_pos : result exceeded the positive limit
//   ovf_neg : result went below the negative limit
module acc_add_sat
  import dsp_pkg::*;
#(
  parameter int ACC_W    = DSP_ACC_W,
  parameter int MULT_W   = DSP_MULT_W,
  parameter int SATURATE = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [MULT_W-1:0] prod,
  input  logic                     sub,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf_pos,
  output logic                     ovf_neg
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] raw_sum;

  function automatic logic signed [ACC_W-1:0] clamp(
    input logic signed [ACC_W-1:0] val,
    input logic                    pos,
    input logic                    neg
  );
    logic signed [ACC_W-1:0] r;
    r = val;
    if (SATURATE != 0) begin
      if (pos)      r = SAT_MAX;
      else if (neg) r = SAT_MIN;
    end
    return r;
  endfunction

  // Negating a sign-extended MULT_W value cannot overflow because ACC_W > MULT_W.
  assign prod_ext = {{(ACC_W-MULT_W){prod[MULT_W-1]}}, prod};
  assign operand  = sub ? -prod_ext : prod_ext;
  assign raw_sum  = acc + operand;

  // Signed overflow: both addends share a sign and the result sign differs.
  assign ovf_pos = ~acc[ACC_W-1] & ~operand[ACC_W-1] &  raw_sum[ACC_W-1];
  assign ovf_neg =  acc[ACC_W-1] &  operand[ACC_W-1] & ~raw_sum[ACC_W-1];

  assign sum = clamp(raw_sum, ovf_pos, ovf_neg);

endmodule

// File: rtl/mult_acc_preg.sv
// Post-multiplier accumulate stage. Accumulates the signed product stream into
// a frame result delimited by M_LAST and publishes it in the P register with a
// one-cycle P_VALID pulse plus overflow/underflow and pattern-detect flags.
//   CLK, RSTP_N   : clock, asynchronous active-low reset
//   CEP           : clock enable; all state holds and P_VALID is 0 when low
//   MULT_OUT      : signed product, M_VALID beat valid, M_LAST end of frame
//   SUB           : per-beat subtract select
//   P, P_VALID    : frame result and its update pulse
//   OVERFLOW, UNDERFLOW, PATTERNDETECT : frame flags, held with P
module mult_acc_preg
  import dsp_pkg::*;
#(
  parameter int               MULT_W   = DSP_MULT_W,
  parameter int               ACC_W    = DSP_ACC_W,
  parameter int               SATURATE = 0,
  parameter logic [ACC_W-1:0] PATTERN  = '0
) (
  input  logic                     CLK,
  input  logic                     RSTP_N,
  input  logic                     CEP,
  input  logic signed [MULT_W-1:0] MULT_OUT,
  input  logic                     M_VALID,
  input  logic                     M_LAST,
  input  logic                     SUB,
  output logic signed [ACC_W-1:0]  P,
  output logic                     P_VALID,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  output logic                     PATTERNDETECT
);

  acc_state_t              state_p0, state_d;
  logic signed [ACC_W-1:0] acc_p0, acc_d;
  logic                    ovf_st_p0, ovf_st_d;
  logic                    unf_st_p0, unf_st_d;

  logic signed [ACC_W-1:0] p_p1, p_d;
  logic                    vld_p1, vld_d;
  logic                    ovf_p1, ovf_d;
  logic                    unf_p1, unf_d;
  logic                    pd_p1, pd_d;

  logic                    beat;
  logic                    frame_open;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf_pos, ovf_neg;
  logic                    ovf_acc, unf_acc;

  assign beat       = CEP & M_VALID;
  assign frame_open = (state_p0 == ACCUM);

  // A beat in IDLE starts from zero with cleared stickies, so the first beat
  // of a frame goes through the same adder path as every other beat.
  assign acc_base = frame_open ? acc_p0 : '0;
  assign ovf_acc  = (frame_open & ovf_st_p0) | ovf_pos;
  assign unf_acc  = (frame_open & unf_st_p0) | ovf_neg;

  acc_add_sat #(
    .ACC_W    (ACC_W),
    .MULT_W   (MULT_W),
    .SATURATE (SATURATE)
  ) u_add (
    .acc     (acc_base),
    .prod    (MULT_OUT),
    .sub     (SUB),
    .sum     (sum),
    .ovf_pos (ovf_pos),
    .ovf_neg (ovf_neg)
  );

  // ---- stage 0: frame FSM and accumulator next state ----
  always_comb begin
    state_d  = state_p0;
    acc_d    = acc_p0;
    ovf_st_d = ovf_st_p0;
    unf_st_d = unf_st_p0;
    p_d      = p_p1;
    ovf_d    = ovf_p1;
    unf_d    = unf_p1;
    pd_d     = pd_p1;
    vld_d    = 1'b0;
    if (beat) begin
      if (M_LAST) begin
        state_d  = IDLE;
        acc_d    = '0;
        ovf_st_d = 1'b0;
        unf_st_d = 1'b0;
        p_d      = sum;
        ovf_d    = ovf_acc;
        unf_d    = unf_acc;
        pd_d     = ($unsigned(sum) == PATTERN);
        vld_d    = 1'b1;
      end else begin
        state_d  = ACCUM;
        acc_d    = sum;
        ovf_st_d = ovf_acc;
        unf_st_d = unf_acc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTP_N) begin
    if (!RSTP_N) begin
      state_p0  <= IDLE;
      acc_p0    <= '0;
      ovf_st_p0 <= 1'b0;
      unf_st_p0 <= 1'b0;
    end else if (CEP) begin
      state_p0  <= state_d;
      acc_p0    <= acc_d;
      ovf_st_p0 <= ovf_st_d;
      unf_st_p0 <= unf_st_d;
    end
  end

  // ---- stage 1: published P register and flags ----
  always_ff @(posedge CLK or negedge RSTP_N) begin
    if (!RSTP_N) begin
      p_p1   <= '0;
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
      pd_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_d;
      if (CEP) begin
        p_p1   <= p_d;
        ovf_p1 <= ovf_d;
        unf_p1 <= unf_d;
        pd_p1  <= pd_d;
      end
    end
  end

  assign P             = p_p1;
  assign P_VALID       = vld_p1;
  assign OVERFLOW      = ovf_p1;
  assign UNDERFLOW     = unf_p1;
  assign PATTERNDETECT = pd_p1;

endmodule

// File: tb/tb_mult_acc_preg.sv
// Directed bench for mult_acc_preg: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-computed constants.
module tb_mult_acc_preg;

  logic               CLK;
  logic               RSTP_N;
  logic               CEP;
  logic signed [42:0] MULT_OUT;
  logic               M_VALID;
  logic               M_LAST;
  logic               SUB;

  logic signed [47:0] p_w, p_s;
  logic               pv_w, pv_s;
  logic               ovf_w, ovf_s;
  logic               unf_w, unf_s;
  logic               pd_w, pd_s;

  int n_tests = 0;
  int n_fail  = 0;

  mult_acc_preg #(.MULT_W(43), .ACC_W(48), .SATURATE(0), .PATTERN(48'd42)) dut_w (
    .CLK(CLK), .RSTP_N(RSTP_N), .CEP(CEP), .MULT_OUT(MULT_OUT), .M_VALID(M_VALID),
    .M_LAST(M_LAST), .SUB(SUB), .P(p_w), .P_VALID(pv_w), .OVERFLOW(ovf_w),
    .UNDERFLOW(unf_w), .PATTERNDETECT(pd_w)
  );

  mult_acc_preg #(.MULT_W(43), .ACC_W(48), .SATURATE(1), .PATTERN(48'd42)) dut_s (
    .CLK(CLK), .RSTP_N(RSTP_N), .CEP(CEP), .MULT_OUT(MULT_OUT), .M_VALID(M_VALID),
    .M_LAST(M_LAST), .SUB(SUB), .P(p_s), .P_VALID(pv_s), .OVERFLOW(ovf_s),
    .UNDERFLOW(unf_s), .PATTERNDETECT(pd_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic beat(input logic signed [42:0] v, input logic s, input logic l);
    MULT_OUT = v; SUB = s; M_LAST = l; M_VALID = 1'b1; CEP = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycle();
    M_VALID = 1'b0; M_LAST = 1'b0; SUB = 1'b0; CEP = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RSTP_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (p_w !== 48'sd0) begin n_fail++; $display("FAIL rst_p got=%0d exp=0", p_w); end
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL rst_pvalid got=%b exp=0", pv_w); end
    n_tests++; if (ovf_w !== 1'b0 || unf_w !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b exp=00", ovf_w, unf_w); end
    n_tests++; if (pd_w !== 1'b0) begin n_fail++; $display("FAIL rst_pd got=%b exp=0", pd_w); end
    RSTP_N = 1'b1;
    idle_cycle();
  endtask

  task automatic test_basic();
    beat(43'sd12, 1'b0, 1'b0);
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL basic_mid_pvalid got=%b exp=0", pv_w); end
    beat(43'sd10, 1'b0, 1'b0);
    beat(-43'sd6, 1'b0, 1'b1);
    n_tests++; if (p_w !== 48'sd16) begin n_fail++; $display("FAIL basic_p got=%0d exp=16", p_w); end
    n_tests++; if (pv_w !== 1'b1) begin n_fail++; $display("FAIL basic_pvalid got=%b exp=1", pv_w); end
    n_tests++; if (ovf_w !== 1'b0 || unf_w !== 1'b0) begin n_fail++; $display("FAIL basic_flags got=%b%b exp=00", ovf_w, unf_w); end
    n_tests++; if (pd_w !== 1'b0) begin n_fail++; $display("FAIL basic_pd got=%b exp=0", pd_w); end
    idle_cycle();
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", pv_w); end
    n_tests++; if (p_w !== 48'sd16) begin n_fail++; $display("FAIL basic_hold got=%0d exp=16", p_w); end
  endtask

  task automatic test_reset_mid_frame();
    beat(43'sd5, 1'b0, 1'b0);
    beat(43'sd7, 1'b0, 1'b0);
    M_VALID = 1'b0; M_LAST = 1'b0;
    RSTP_N = 1'b0;
    #2;
    n_tests++; if (p_w !== 48'sd0) begin n_fail++; $display("FAIL midrst_p got=%0d exp=0", p_w); end
    n_tests++; if (pv_w !== 1'b0 || ovf_w !== 1'b0 || unf_w !== 1'b0 || pd_w !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got=%b%b%b%b exp=0000", pv_w, ovf_w, unf_w, pd_w); end
    @(posedge CLK); #1;
    RSTP_N = 1'b1;
    beat(43'sd2, 1'b0, 1'b1);
    n_tests++; if (p_w !== 48'sd2) begin n_fail++; $display("FAIL midrst_newframe_p got=%0d exp=2", p_w); end
    n_tests++; if (pv_w !== 1'b1) begin n_fail++; $display("FAIL midrst_newframe_pvalid got=%b exp=1", pv_w); end
    idle_cycle();
  endtask

  task automatic test_sub_back_to_back();
    beat(43'sd100, 1'b0, 1'b0);
    beat(43'sd30, 1'b1, 1'b1);
    n_tests++; if (p_w !== 48'sd70) begin n_fail++; $display("FAIL sub_p got=%0d exp=70", p_w); end
    n_tests++; if (pv_w !== 1'b1) begin n_fail++; $display("FAIL sub_pvalid got=%b exp=1", pv_w); end
    beat(43'sd9, 1'b0, 1'b1);
    n_tests++; if (p_w !== 48'sd9) begin n_fail++; $display("FAIL b2b_p got=%0d exp=9", p_w); end
    n_tests++; if (pv_w !== 1'b1) begin n_fail++; $display("FAIL b2b_pvalid got=%b exp=1", pv_w); end
    idle_cycle();
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end got=%b exp=0", pv_w); end
  endtask

  task automatic test_overflow();
    logic signed [42:0] maxp;
    logic signed [42:0] minp;
    maxp = 43'sh3FF_FFFF_FFFF;
    minp = 43'sh400_0000_0000;
    for (int i = 0; i < 40; i++) beat(maxp, 1'b0, (i == 39));
    n_tests++; if (p_w !== 48'sh9FFF_FFFF_FFD8) begin n_fail++; $display("FAIL wrap_pos_p got=%h exp=9fffffffffd8", p_w); end
    n_tests++; if (ovf_w !== 1'b1 || unf_w !== 1'b0) begin n_fail++; $display("FAIL wrap_pos_flags got=%b%b exp=10", ovf_w, unf_w); end
    n_tests++; if (p_s !== 48'sh7FFF_FFFF_FFFF) begin n_fail++; $display("FAIL sat_pos_p got=%h exp=7fffffffffff", p_s); end
    n_tests++; if (ovf_s !== 1'b1 || unf_s !== 1'b0) begin n_fail++; $display("FAIL sat_pos_flags got=%b%b exp=10", ovf_s, unf_s); end
    n_tests++; if (pv_s !== 1'b1) begin n_fail++; $display("FAIL sat_pos_pvalid got=%b exp=1", pv_s); end
    idle_cycle();
    for (int i = 0; i < 40; i++) beat(minp, 1'b0, (i == 39));
    n_tests++; if (p_w !== 48'sh6000_0000_0000) begin n_fail++; $display("FAIL wrap_neg_p got=%h exp=600000000000", p_w); end
    n_tests++; if (unf_w !== 1'b1 || ovf_w !== 1'b0) begin n_fail++; $display("FAIL wrap_neg_flags got=%b%b exp=01", ovf_w, unf_w); end
    n_tests++; if (p_s !== 48'sh8000_0000_0000) begin n_fail++; $display("FAIL sat_neg_p got=%h exp=800000000000", p_s); end
    n_tests++; if (unf_s !== 1'b1 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL sat_neg_flags got=%b%b exp=01", ovf_s, unf_s); end
    idle_cycle();
    beat(43'sd1, 1'b0, 1'b1);
    n_tests++; if (ovf_w !== 1'b0 || unf_w !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got=%b%b exp=00", ovf_w, unf_w); end
    idle_cycle();
  endtask

  task automatic test_cep_stall();
    beat(43'sd10, 1'b0, 1'b0);
    MULT_OUT = 43'sd99; M_VALID = 1'b1; M_LAST = 1'b1; SUB = 1'b0; CEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL cep_stall_pvalid cycle=%0d got=%b exp=0", i, pv_w); end
    end
    n_tests++; if (p_w !== 48'sd1) begin n_fail++; $display("FAIL cep_stall_hold got=%0d exp=1", p_w); end
    beat(43'sd20, 1'b0, 1'b1);
    n_tests++; if (p_w !== 48'sd30) begin n_fail++; $display("FAIL cep_p got=%0d exp=30", p_w); end
    n_tests++; if (pv_w !== 1'b1) begin n_fail++; $display("FAIL cep_pvalid got=%b exp=1", pv_w); end
    M_VALID = 1'b0; M_LAST = 1'b0; CEP = 1'b0;
    @(posedge CLK); #1;
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL cep_no_repeat got=%b exp=0", pv_w); end
    idle_cycle();
  endtask

  task automatic test_pattern();
    beat(43'sd42, 1'b0, 1'b1);
    n_tests++; if (pd_w !== 1'b1) begin n_fail++; $display("FAIL pattern_hit got=%b exp=1", pd_w); end
    n_tests++; if (p_w !== 48'sd42) begin n_fail++; $display("FAIL pattern_hit_p got=%0d exp=42", p_w); end
    idle_cycle();
    n_tests++; if (pd_w !== 1'b1) begin n_fail++; $display("FAIL pattern_hold got=%b exp=1", pd_w); end
    beat(43'sd41, 1'b0, 1'b1);
    n_tests++; if (pd_w !== 1'b0) begin n_fail++; $display("FAIL pattern_miss got=%b exp=0", pd_w); end
    idle_cycle();
  endtask

  task automatic test_last_without_valid();
    MULT_OUT = 43'sd77; M_VALID = 1'b0; M_LAST = 1'b1; SUB = 1'b0; CEP = 1'b1;
    @(posedge CLK); #1;
    n_tests++; if (pv_w !== 1'b0) begin n_fail++; $display("FAIL last_novalid_pvalid got=%b exp=0", pv_w); end
    beat(43'sd5, 1'b0, 1'b0);
    beat(43'sd6, 1'b0, 1'b1);
    n_tests++; if (p_w !== 48'sd11) begin n_fail++; $display("FAIL last_novalid_p got=%0d exp=11", p_w); end
    idle_cycle();
  endtask

  initial begin
    RSTP_N = 1'b0; CEP = 1'b0; MULT_OUT = '0; M_VALID = 1'b0; M_LAST = 1'b0; SUB = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid_frame();
    test_sub_back_to_back();
    test_overflow();
    test_cep_stall();
    test_pattern();
    test_last_without_valid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
